// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM encoding, memory geometry.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package load_store_unit_pkg;

    localparam int MEM_WORDS_DEF = 256;
    localparam int IDX_W_DEF     = 8;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_MERGE_WR = 2'd2,
        ST_RESP     = 2'd3
    } lsu_state_t;

    // Op codes are ordered so that every load sits below the first store.
    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LBU);
    endfunction

    // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = off[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte/halfword lane steering: extends load lanes and merges store lanes into a word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane selection and sign/zero extension for loads.
    always_comb begin
        byte_sel  = word[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (op)
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = word;
        endcase
    end

    // Overlay the store lane onto the previously read word for sub-word stores.
    always_comb begin
        merged = word;
        case (op)
            OP_SB:   merged[{offset, 3'b000} +: 8]        = wdata[7:0];
            OP_SH:   merged[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a single-port word memory with sub-word access and error checks.
// Latency: error 1 cycle, load/SW 2 cycles, SH/SB 3 cycles from request handshake to resp_valid.
// Backpressure: one op in flight; req_ready only in IDLE, RESP holds until resp_ready.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_memwrite,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    lsu_state_t  state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic [IDX_W-1:0] req_idx;
    logic             req_oor;
    logic             req_bad;
    logic [31:0]      load_data;
    logic [31:0]      merged;

    // Decode the incoming request; anything past the last word is rejected.
    always_comb begin
        req_idx = req_addr[IDX_W+1:2];
        req_oor = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        req_bad = req_oor || is_misaligned(req_op, req_addr[1:0]);
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    // The lane logic always works on the live read data of the latched index.
    lane_align u_lane (
        .word      (mem_readdata),
        .offset    (off_q),
        .op        (op_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Control FSM with registered memory strobes and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_q          <= OP_LW;
            off_q         <= 2'b00;
            wdata_q       <= '0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            mem_memwrite  <= 1'b0;
            mem_endereco  <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        off_q      <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        if (req_bad) begin
                            // No memory cycle for a rejected request.
                            resp_err <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            resp_err     <= 1'b0;
                            mem_endereco <= {{(32-IDX_W){1'b0}}, req_idx};
                            if (req_op == OP_SW) begin
                                mem_memwrite  <= 1'b1;
                                mem_writedata <= req_wdata;
                            end
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (is_load(op_q)) begin
                        resp_rdata <= load_data;
                        state      <= ST_RESP;
                    end else if (op_q == OP_SW) begin
                        mem_memwrite <= 1'b0;
                        state        <= ST_RESP;
                    end else begin
                        // Sub-word store: write back the merged word next cycle.
                        mem_writedata <= merged;
                        mem_memwrite  <= 1'b1;
                        state         <= ST_MERGE_WR;
                    end
                end
                ST_MERGE_WR: begin
                    mem_memwrite <= 1'b0;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
// Latency: checks response latency and write-cycle timing per request.
// Backpressure: exercises a held-off resp_ready with a pending request.
module tb_load_store_unit;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_memwrite;
    logic [31:0] mem_endereco;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    load_store_unit #(.MEM_WORDS(256), .IDX_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_memwrite  (mem_memwrite),
        .mem_endereco  (mem_endereco),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:255];
    assign mem_readdata = mem[mem_endereco[7:0]];
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_endereco[7:0]] <= mem_writedata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int          wr_cnt = 0;
    logic [31:0] wr_idx = '0;
    logic [31:0] wr_dat = '0;
    int          wr_cyc = 0;
    logic        seen = 1'b0;

    // Response monitor: pops the scoreboard on each response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (mem_memwrite) begin
                wr_cnt++;
                wr_idx = mem_endereco;
                wr_dat = mem_writedata;
                wr_cyc = cyc;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("resp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        seen = 1'b1;
                    end
                    chk("resp_rdata", resp_rdata, sb[0].rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, sb[0].err});
                    chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
                    chk("memwrite_in_resp", {31'b0, mem_memwrite}, 32'd0);
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Drive a request from a negedge, wait for acceptance, push the expected response.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         output int acc);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        acc     = cyc;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = acc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         output int acc);
        issue(op, addr, wd, exp_rd, exp_err, exp_lat, acc);
        wait_done();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_memwrite"}, {31'b0, mem_memwrite}, 32'd0);
        chk({tag, "_endereco"}, mem_endereco, 32'd0);
        chk({tag, "_writedata"}, mem_writedata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int w0;
        int rel;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // SW then LW through the same word.
        w0 = wr_cnt;
        do_op(SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, acc);
        chk("sw_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sw_index", wr_idx, 32'd4);
        chk("sw_wdata", wr_dat, 32'hDEADBEEF);
        chk("sw_wr_cycle", 32'(wr_cyc - acc), 32'd1);
        do_op(LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, acc);

        // Sub-word loads from 0x80FF7F01.
        do_op(SW, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 2, acc);
        w0 = wr_cnt;
        do_op(LB,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, acc);
        do_op(LBU, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, acc);
        do_op(LH,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, acc);
        do_op(LHU, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2, acc);
        do_op(LB,  32'h21, 32'h0, 32'h0000007F, 1'b0, 2, acc);
        chk("loads_no_write", 32'(wr_cnt - w0), 32'd0);

        // Read-modify-write stores.
        do_op(SW, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, acc);
        w0 = wr_cnt;
        do_op(SB, 32'h21, 32'h000000AA, 32'h0, 1'b0, 3, acc);
        chk("sb_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sb_index", wr_idx, 32'd8);
        chk("sb_merged", wr_dat, 32'h1122AA44);
        chk("sb_wr_cycle", 32'(wr_cyc - acc), 32'd2);
        w0 = wr_cnt;
        do_op(SH, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 3, acc);
        chk("sh_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sh_merged", wr_dat, 32'hBEEFAA44);
        do_op(LW, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2, acc);

        // Error cases: no memory write, zero data.
        w0 = wr_cnt;
        do_op(LW, 32'h02, 32'h0, 32'h0, 1'b1, 1, acc);
        do_op(SH, 32'h05, 32'h1234, 32'h0, 1'b1, 1, acc);
        do_op(SW, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, 1, acc);
        do_op(SB, 32'hFFFF_FFFF, 32'h55, 32'h0, 1'b1, 1, acc);
        chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
        do_op(LW, 32'h3FC, 32'h0, mem[255], 1'b0, 2, acc);

        // Response backpressure with a pending request.
        resp_ready = 1'b0;
        issue(LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, acc);
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 32'h20;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        rel = cyc;
        @(negedge clk);
        chk("stall_release_resp_valid", {31'b0, resp_valid}, 32'd0);
        issue(LW, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2, acc2);
        chk("stall_accept_cycle", 32'(acc2 - rel), 32'd1);
        wait_done();

        // Reset in the middle of an SB write-back.
        issue(SB, 32'h20, 32'h00000055, 32'h0, 1'b0, 3, acc);
        @(negedge clk);
        chk("abort_merge_strobe", {31'b0, mem_memwrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk("abort_mem_unchanged", mem[8], 32'hBEEFAA44);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        do_op(LW, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the single-port data memory: accepts load/store requests from the datapath and drives the memory's memwrite/address/writedata.
- Memory ports: combinational read, write on posedge clk, word-indexed.
- Adds byte/halfword loads (sign/zero-extended) and stores via read-modify-write, alignment and range checking, and a valid/ready request/response handshake.
- Sits between the execute stage (address = ALU result) and the data memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory.
- IDX_W, 8, word-index width; must equal log2(MEM_WORDS).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range; no memory write performed.
- mem_memwrite  output  1  write strobe to data memory.
- mem_endereco  output  32  word index, zero-extended from IDX_W bits.
- mem_writedata  output  32  full word to write.
- mem_readdata  input  32  combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_memwrite=0, mem_endereco=0, mem_writedata=0.
  - Reset during any state aborts the operation. memwrite drops immediately, so no partial or merged write is committed, and no response is issued.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - On req_valid && req_ready, latch op, addr and wdata. The word index is addr[IDX_W+1:2]; the byte offset is addr[1:0].
  - Error check: halfword ops require addr[0]=0; word ops require addr[1:0]=0; any op with addr[31:IDX_W+2] nonzero is out of range.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No memory cycle is issued.
  - Otherwise: go to ACCESS.
- ACCESS (one cycle): mem_endereco = latched index.
  - Loads: capture mem_readdata at the clock edge, select the lane (little-endian, offset picks the byte or half), sign-extend for LB/LH, zero-extend for LBU/LHU, then go to RESP.
  - SW: mem_memwrite=1 and mem_writedata=wdata in this cycle, then go to RESP.
  - SH/SB: capture mem_readdata, merge the store lane into the captured word, then go to MERGE_WR.
- MERGE_WR (one cycle): mem_memwrite=1 and mem_writedata=merged word, index held, then go to RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1.
  - On the handshake edge, return to IDLE.
  - req_ready=0, so a new request arriving during RESP stalls.
- mem_memwrite is high for exactly one cycle per successful store and never in IDLE or RESP.
- Outside write cycles, mem_endereco holds the last index and mem_writedata holds its last value.
- Latency (request handshake at edge N):
  - Errors: resp_valid from N+1.
  - Loads and SW: resp_valid from N+2.
  - SH/SB: resp_valid from N+3.
  - resp_ready held high gives a 1-cycle RESP; the next request can be accepted one cycle later.
- Back-to-back ordering: a load after a store to the same word returns the written data, because the write is committed before RESP.

Decomposition:
- Shared package:
  - Op-code localparams (LW..SB).
  - FSM state encoding.
  - MEM_WORDS/IDX_W defaults.
- Sub-module lane_align, pure combinational:
  - Load path: word + offset + op -> extended load value.
  - Store path: old word + offset + op + wdata -> merged word.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Reset: rst_n=0 → all outputs 0 except req_ready=1. Assert rst_n low during MERGE_WR of an SB → mem_memwrite falls immediately; memory word unchanged.
- SW then LW: SW addr 0x10, data 0xDEADBEEF → single memwrite pulse, mem_endereco=4, writedata=0xDEADBEEF, resp_valid at N+2. Then LW 0x10 → resp_rdata=0xDEADBEEF.
- Sub-word loads with word 0x80FF7F01 at byte 0x20:
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- RMW stores:
  - SB 0x21, data 0x000000AA on word 0x11223344 → write 0x1122AA44 one cycle after ACCESS, resp_valid at N+3.
  - SH 0x22, data 0xBEEF → word becomes 0xBEEFAA44.
- Errors:
  - LW 0x02 → resp_err=1 at N+1, no memwrite.
  - SH 0x05 → resp_err=1.
  - SW 0x400 (index beyond 255) → resp_err=1, memory untouched.
- Handshake stall: hold resp_ready=0 for 5 cycles after a LW → resp_valid and resp_rdata stay stable, req_ready=0, and a pending req_valid is not accepted until the cycle after resp_ready=1.
